// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode-to-execute pipeline register.
// Decodes the instruction offered by fetch, selects ALU operands, computes
// branch/jump targets and registers everything for the execute stage behind
// a valid/ready handshake with one cycle of latency and no skid buffer.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   in_valid / in_ready     upstream handshake
//   instr, pc               instruction word and its address
//   rs1_data, rs2_data      register-file read data for instr[19:15] / instr[24:20]
//   flush                   kill the held entry and the entry offered this cycle
//   out_valid / out_ready   downstream handshake
//   alu_control             {0, br, f7b5, funct3}; 6'b111111 for JAL/JALR
//   operand_a, operand_b    ALU operands
//   out_pc                  registered pc (RESET_PC while empty after reset)
//   rd_addr, rd_wen         destination register and writeback enable
//   is_branch, is_jump      control-flow flags
//   target                  branch/jump target
//   illegal                 unsupported encoding
//
// Optional build macro ID_EX_FWD_EN adds wb_wen, wb_rd, wb_data so a writeback
// in the same cycle overrides the register-file read data captured at load.
module id_ex_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
`ifdef ID_EX_FWD_EN
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      alu_control,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rd_addr,
  output logic            rd_wen,
  output logic            is_branch,
  output logic            is_jump,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_v, rs2_v;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign rd    = instr[11:7];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

`ifdef ID_EX_FWD_EN
  assign rs1_v = (wb_wen && (wb_rd == instr[19:15]) && (wb_rd != 5'd0)) ? wb_data : rs1_data;
  assign rs2_v = (wb_wen && (wb_rd == instr[24:20]) && (wb_rd != 5'd0)) ? wb_data : rs2_data;
`else
  assign rs1_v = rs1_data;
  assign rs2_v = rs2_data;
`endif

  // Decoded next-entry fields
  logic [5:0]      ctrl_d;
  logic [XLEN-1:0] a_d, b_d, tgt_d;
  logic [4:0]      rd_d;
  logic            writes, br_d, jmp_d, ill_d;

  always_comb begin
    ctrl_d = '0;
    a_d    = '0;
    b_d    = '0;
    tgt_d  = '0;
    writes = 1'b0;
    br_d   = 1'b0;
    jmp_d  = 1'b0;
    ill_d  = 1'b0;
    case (opc)
      OPC_OP: begin
        ctrl_d = {2'b00, ((f3 == 3'b000) || (f3 == 3'b101)) ? instr[30] : 1'b0, f3};
        a_d    = rs1_v;
        b_d    = rs2_v;
        writes = 1'b1;
      end
      OPC_OPIMM: begin
        // ADDI with bit30 set is still ADD; only the right shifts honour bit30
        ctrl_d = {2'b00, (f3 == 3'b101) ? instr[30] : 1'b0, f3};
        a_d    = rs1_v;
        b_d    = ((f3 == 3'b001) || (f3 == 3'b101)) ? {27'b0, instr[24:20]} : imm_i;
        writes = 1'b1;
      end
      OPC_BRANCH: begin
        if (f3[2:1] == 2'b01) begin
          ill_d = 1'b1;
        end else begin
          ctrl_d = {3'b010, f3};
          a_d    = rs1_v;
          b_d    = rs2_v;
          br_d   = 1'b1;
          tgt_d  = pc + imm_b;
        end
      end
      OPC_JAL: begin
        ctrl_d = 6'b111111;
        a_d    = pc + 32'd4;
        jmp_d  = 1'b1;
        tgt_d  = pc + imm_j;
        writes = 1'b1;
      end
      OPC_JALR: begin
        ctrl_d = 6'b111111;
        a_d    = pc + 32'd4;
        jmp_d  = 1'b1;
        tgt_d  = (rs1_v + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
        writes = 1'b1;
      end
      OPC_LUI: begin
        b_d    = imm_u;
        writes = 1'b1;
      end
      OPC_AUIPC: begin
        a_d    = pc;
        b_d    = imm_u;
        writes = 1'b1;
      end
      OPC_LOAD: begin
        a_d    = rs1_v;
        b_d    = imm_i;
        writes = 1'b1;
      end
      OPC_STORE: begin
        a_d = rs1_v;
        b_d = imm_s;
      end
      default: ill_d = 1'b1;
    endcase
  end

  // Instructions without a destination report rd_addr = 0
  assign rd_d = writes ? rd : 5'd0;

  // Handshake
  logic valid_q, valid_d, load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (load)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  logic [5:0]      ctrl_q;
  logic [XLEN-1:0] a_q, b_q, pc_q, tgt_q;
  logic [4:0]      rd_q;
  logic            wen_q, br_q, jmp_q, ill_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      br_q    <= 1'b0;
      jmp_q   <= 1'b0;
      tgt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        ctrl_q <= ctrl_d;
        a_q    <= a_d;
        b_q    <= b_d;
        pc_q   <= pc;
        rd_q   <= rd_d;
        wen_q  <= writes && (rd_d != 5'd0);
        br_q   <= br_d;
        jmp_q  <= jmp_d;
        tgt_q  <= tgt_d;
        ill_q  <= ill_d;
      end
    end
  end

  assign out_valid   = valid_q;
  assign alu_control = ctrl_q;
  assign operand_a   = a_q;
  assign operand_b   = b_q;
  assign out_pc      = pc_q;
  assign rd_addr     = rd_q;
  assign rd_wen      = wen_q;
  assign is_branch   = br_q;
  assign is_jump     = jmp_q;
  assign target      = tgt_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes hand-computed expected
// entries, a monitor pops and compares each entry as execute consumes it and
// checks that held outputs stay stable while out_ready is low.
module tb_id_ex_stage;

  localparam logic [31:0] RPC = 32'h0000_1000;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic        br;
    logic        jmp;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [5:0]  alu_control;
  logic [31:0] operand_a, operand_b, out_pc, target;
  logic [4:0]  rd_addr;
  logic        rd_wen, is_branch, is_jump, illegal;
`ifdef ID_EX_FWD_EN
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush),
`ifdef ID_EX_FWD_EN
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .operand_a(operand_a), .operand_b(operand_b), .out_pc(out_pc),
    .rd_addr(rd_addr), .rd_wen(rd_wen), .is_branch(is_branch), .is_jump(is_jump),
    .target(target), .illegal(illegal)
  );

  function automatic exp_t mk(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] p, input logic [4:0] rd, input logic w,
                              input logic br, input logic j, input logic [31:0] t, input logic il);
    exp_t e;
    e.ctrl = c; e.a = a; e.b = b; e.pc = p; e.rd = rd;
    e.wen = w; e.br = br; e.jmp = j; e.tgt = t; e.ill = il;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t e;
    e.ctrl = alu_control; e.a = operand_a; e.b = operand_b; e.pc = out_pc; e.rd = rd_addr;
    e.wen = rd_wen; e.br = is_branch; e.jmp = is_jump; e.tgt = target; e.ill = illegal;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compare on consumption, check stability while held
  logic prev_hold = 1'b0;
  exp_t snap;
  always @(negedge clk) begin
    exp_t act, e;
    act = actual();
    if (prev_hold && out_valid) begin
      n_tests++;
      if (act !== snap) begin
        n_fail++;
        $display("FAIL hold_stable: got %h, expected %h", act, snap);
      end
    end
    if (out_valid && out_ready && !reset) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h, expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL entry pc=%h: got %h, expected %h", e.pc, act, e);
        end
      end
    end
    prev_hold = out_valid && !out_ready && !reset;
    snap      = act;
  end

  // Offer one instruction; returns #1 after the edge on which it was taken
  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                      input logic [31:0] r2, input exp_t e, input logic fl);
    bit acc = 0;
    int n   = 0;
    instr = i; pc = p; rs1_data = r1; rs2_data = r2; flush = fl; in_valid = 1'b1;
    while (!acc && n < 20) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        if (!fl) exp_q.push_back(e);
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout pc=%h: got in_ready=0 for 20 cycles, expected 1", p);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
`ifdef ID_EX_FWD_EN
    wb_wen = 1'b0; wb_rd = '0; wb_data = '0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset_out_pc", {32'b0, out_pc}, {32'b0, RPC});
    chk("reset_others", {58'b0, alu_control} | {32'b0, operand_a} | {32'b0, operand_b}
        | {32'b0, target} | {59'b0, rd_addr} | {60'b0, rd_wen, is_branch, is_jump, illegal}, 64'd0);
    @(posedge clk); #1;

    // sub x0,x1,x2 : rd_wen forced low for x0, 1-cycle latency
    send(32'h40208033, 32'h10, 32'd5, 32'd7, mk(6'h08, 5, 7, 32'h10, 0, 0, 0, 0, 0, 0), 0);
    @(negedge clk);
    chk("latency_out_valid", {63'b0, out_valid}, 64'd1);
    @(posedge clk); #1;
    send(32'h4030D093, 32'h14, 32'h80000000, 0, mk(6'h0D, 32'h80000000, 3, 32'h14, 1, 1, 0, 0, 0, 0), 0);
    send(32'hFFF30293, 32'h18, 32'd10, 0, mk(6'h00, 10, 32'hFFFFFFFF, 32'h18, 5, 1, 0, 0, 0, 0), 0);
    send(32'h40030293, 32'h1C, 32'd10, 0, mk(6'h00, 10, 32'h400, 32'h1C, 5, 1, 0, 0, 0, 0), 0);
    send(32'h4020C1B3, 32'h20, 32'h0F, 32'h33, mk(6'h04, 32'h0F, 32'h33, 32'h20, 3, 1, 0, 0, 0, 0), 0);
    send(32'hFE208EE3, 32'h200, 32'd3, 32'd3, mk(6'h10, 3, 3, 32'h200, 0, 0, 1, 0, 32'h1FC, 0), 0);
    send(32'h123453B7, 32'h204, 32'd99, 0, mk(6'h00, 0, 32'h12345000, 32'h204, 7, 1, 0, 0, 0, 0), 0);
    send(32'h00001197, 32'h400, 0, 0, mk(6'h00, 32'h400, 32'h1000, 32'h400, 3, 1, 0, 0, 0, 0), 0);
    send(32'h005100E7, 32'h300, 32'h1000, 0, mk(6'h3F, 32'h304, 0, 32'h300, 1, 1, 0, 1, 32'h1004, 0), 0);
    send(32'hFE20AC23, 32'h304, 32'h100, 32'h55, mk(6'h00, 32'h100, 32'hFFFFFFF8, 32'h304, 0, 0, 0, 0, 0, 0), 0);
    send(32'h00002063, 32'h308, 1, 2, mk(6'h00, 0, 0, 32'h308, 0, 0, 0, 0, 0, 1), 0);
    send(32'h0000007F, 32'h30C, 1, 2, mk(6'h00, 0, 0, 32'h30C, 0, 0, 0, 0, 0, 1), 0);
    send(32'h008000EF, 32'hFFFFFFFC, 0, 0, mk(6'h3F, 0, 0, 32'hFFFFFFFC, 1, 1, 0, 1, 32'h4, 0), 0);

    // Backpressure: A held while B waits 3 cycles, B loads when out_ready returns
    send(32'h002081B3, 32'h500, 32'd1, 32'd2, mk(6'h00, 1, 2, 32'h500, 3, 1, 0, 0, 0, 0), 0);
    out_ready = 1'b0;
    instr = 32'h40208133; pc = 32'h504; rs1_data = 32'd10; rs2_data = 32'd4; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {63'b0, in_ready}, 64'd1);
    exp_q.push_back(mk(6'h08, 10, 4, 32'h504, 2, 1, 0, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Flush beats load; then the same JAL without flush
    @(negedge clk); @(posedge clk); #1;
    send(32'h008000EF, 32'h100, 0, 0, mk('0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    @(negedge clk);
    chk("flush_load_out_valid", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    send(32'h008000EF, 32'h100, 0, 0, mk(6'h3F, 32'h104, 0, 32'h100, 1, 1, 0, 1, 32'h108, 0), 0);
    @(negedge clk); @(posedge clk); #1;

    // Flush of a held entry
    out_ready = 1'b0;
    send(32'h002081B3, 32'h600, 1, 2, mk(6'h00, 1, 2, 32'h600, 3, 1, 0, 0, 0, 0), 0);
    void'(exp_q.pop_back());
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_held_out_valid", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Reset mid-transfer drops the held entry
    send(32'h002081B3, 32'h700, 1, 2, mk(6'h00, 1, 2, 32'h700, 3, 1, 0, 0, 0, 0), 0);
    void'(exp_q.pop_back());
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_mid_out_pc", {32'b0, out_pc}, {32'b0, RPC});
    @(posedge clk); #1;
    out_ready = 1'b1;

`ifdef ID_EX_FWD_EN
    wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
    send(32'h002081B3, 32'h800, 1, 2, mk(6'h00, 9, 2, 32'h800, 3, 1, 0, 0, 0, 0), 0);
    wb_rd = 5'd0;
    send(32'h002081B3, 32'h804, 1, 2, mk(6'h00, 1, 2, 32'h804, 3, 1, 0, 0, 0, 0), 0);
    wb_wen = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
